// File: rtl/seq_stream_ctrl_pkg.sv
// Shared types and defaults for the serial pattern-detector feed controller.
package seq_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StShift  = 3'd2,
    StDrain  = 3'd3,
    StReport = 3'd4
  } state_e;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefBitCycles = 2;
  localparam int unsigned DefDrainBits = 2;
  localparam int unsigned DefCntW      = 6;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period timer: divides each serial bit into BIT_CYCLES clocks and tracks bit position
// across the word and the trailing drain bits.
module seq_bit_timer
  import seq_stream_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned BIT_CYCLES = DefBitCycles,
  parameter int unsigned DRAIN_BITS = DefDrainBits
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic bit_end,
  output logic word_end,
  output logic drain_end
);

  localparam int unsigned TickW = clog2_min1(BIT_CYCLES);
  localparam int unsigned IdxW  = clog2_min1(WIDTH + DRAIN_BITS + 1);

  logic [TickW-1:0] tick_q;
  logic [IdxW-1:0]  bit_idx_q;

  assign bit_end   = run && (tick_q == TickW'(BIT_CYCLES - 1));
  assign word_end  = bit_end && (bit_idx_q == IdxW'(WIDTH - 1));
  assign drain_end = bit_end && (bit_idx_q == IdxW'(WIDTH + DRAIN_BITS - 1));

  // bit_idx keeps counting through the drain bits so one comparator marks each phase end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q    <= '0;
      bit_idx_q <= '0;
    end else if (start) begin
      tick_q    <= '0;
      bit_idx_q <= '0;
    end else if (run) begin
      if (bit_end) begin
        tick_q    <= '0;
        bit_idx_q <= bit_idx_q + 1'b1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Feeds a serial pattern detector from a valid/ready word source and reports the number
// of detector flags seen per word.
module seq_stream_ctrl
  import seq_stream_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned BIT_CYCLES    = DefBitCycles,
  parameter int unsigned DRAIN_BITS    = DefDrainBits,
  parameter bit          IDLE_LEVEL    = 1'b0,
  parameter bit          CLEAR_ON_LOAD = 1'b1,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             det_seq,
  output logic             det_reset,
  input  logic             det_flag,
  output logic             done_valid,
  output logic [CNT_W-1:0] done_count,
  output logic             done_ovf,
  input  logic             done_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             accept, run, bit_end, word_end, drain_end;

  assign accept = (state_q == StIdle) && load_valid;
  assign run    = (state_q == StShift) || (state_q == StDrain);

  seq_bit_timer #(
    .WIDTH      (WIDTH),
    .BIT_CYCLES (BIT_CYCLES),
    .DRAIN_BITS (DRAIN_BITS)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .run       (run),
    .bit_end   (bit_end),
    .word_end  (word_end),
    .drain_end (drain_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load_valid) state_d = StClear;
      StClear:  state_d = StShift;
      StShift:  if (word_end) state_d = (DRAIN_BITS == 0) ? StReport : StDrain;
      StDrain:  if (drain_end) state_d = StReport;
      StReport: if (done_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shreg_q <= load_data;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (!abort && bit_end) begin
        if (state_q == StShift) shreg_q <= shreg_q << 1;
        // Saturate rather than wrap; the first lost increment raises ovf.
        if (det_flag) begin
          if (count_q == {CNT_W{1'b1}}) ovf_q <= 1'b1;
          else                          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done_valid = (state_q == StReport);
  assign done_count = count_q;
  assign done_ovf   = ovf_q;
  assign det_seq    = (state_q == StShift) ? shreg_q[WIDTH-1] : IDLE_LEVEL;
  assign det_reset  = !(CLEAR_ON_LOAD && (state_q == StClear));

endmodule
